mem_store_unit: RTL
===================

Name: mem_store_unit

Overview:
- Memory-side responder for the commit-stage store interface.
- Accepts one committed store request (address, word data, length code) and serialises it onto the 8-bit RAM write port, one byte per cycle, least-significant byte first.
- Waits for the memory arbiter grant, honours `rdy` and the I/O buffer back-pressure, then returns a one-cycle done pulse to the commit stage.
- Sits inside the memory controller, alongside the instruction-fetch and load paths that share the RAM port through the arbiter.

Parameters:
- ADDR_W, 32, address width in bits.
- WORD_W, 32, store data width in bits.
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped I/O region.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global ready; low freezes the block.
- st_ena  in  1  store request pulse from commit stage.
- st_addr  in  ADDR_W  byte address of the store.
- st_data  in  WORD_W  store data; byte k is bits [8k+7:8k].
- st_len  in  4  length code; bytes written = st_len[1:0]+1 (0=SB, 1=SH, 3=SW).
- st_done  out  1  one-cycle pulse when the last byte has been written.
- st_busy  out  1  high while a store is in progress.
- mem_req  out  1  request for the RAM port, sent to the arbiter.
- mem_gnt  in  1  arbiter grant, valid in the same cycle as mem_req.
- mem_a  out  ADDR_W  RAM byte address.
- mem_dout  out  8  RAM write data.
- mem_wr  out  1  RAM write strobe (1 = write).
- io_buffer_full  in  1  I/O output buffer full.

Behaviour:

States:
- IDLE and WRITE.
- Registers: `addr_r`, `data_r`, `last_r` (2 bits), `cnt` (2 bits), `done_r`.

Reset (async, any state):
- state=IDLE, cnt=0, done_r=0.
- Resulting outputs: st_done=0, st_busy=0, mem_req=0, mem_wr=0, mem_a=0, mem_dout=0.
- A store interrupted by reset is abandoned and st_done is never pulsed for it.

rdy=0:
- State, cnt and all registers hold.
- mem_wr=0; done_r still clears at the next edge.

IDLE:
- If st_ena=1 at a rising edge, latch addr_r=st_addr, data_r=st_data, last_r=st_len[1:0], set cnt=0, and go to WRITE.
- st_len[3:2] is ignored.

WRITE:
- mem_req=1 and st_busy=1.
- Define `io` = (addr_r[17:16]==IO_HI) and `fire` = mem_gnt & rdy & ~(io & io_buffer_full).
- When fire=1, drive combinationally in that cycle: mem_wr=1, mem_a=addr_r+cnt (mod 2^ADDR_W), mem_dout=data_r[8*cnt+7:8*cnt].
- When fire=0: mem_wr=0, mem_a=0, mem_dout=0.
- On fire with cnt<last_r: cnt increments.
- On fire with cnt==last_r: go to IDLE and set done_r=1 for exactly one cycle.
- st_done=done_r (registered), so st_done rises on the cycle after the last byte is written.

Request acceptance and ordering:
- st_ena while in WRITE is ignored. The commit stage guarantees no overlap; an ignored request produces no write and no done.
- st_ena in the same cycle st_done is high (state already IDLE) is accepted.
- Latency for a SW with constant grant: accept at edge T, bytes written in cycles T+1..T+4, st_done high in cycle T+5.
- Bytes are always written in ascending address order. No alignment check is made; a misaligned SH/SW simply writes consecutive bytes, and address wrap-around is modulo 2^ADDR_W.
- There is no flush input: a store accepted before a pipeline rollback always completes.

Test Plan:
- SW: st_addr=0x1000, st_data=0xDEADBEEF, st_len=3, mem_gnt=1 -> mem_wr writes EF@0x1000, BE@0x1001, AD@0x1002, DE@0x1003 in cycles T+1..T+4; st_done=1 only in T+5; st_busy low from T+5.
- SH with grant gaps: st_addr=0x2002, st_data=0x0000A55A, st_len=1, mem_gnt=0,1,0,1 -> 5A@0x2002 in cycle 2, A5@0x2003 in cycle 4, no mem_wr in gap cycles, st_done in cycle 5.
- I/O back-pressure: SB st_addr=0x30000, st_data=0x41, io_buffer_full high for 3 cycles then low -> no write while full; single write 0x41@0x30000 on the first non-full cycle; st_done one cycle later.
- Overlap and back-to-back: second st_ena during a SW -> ignored, exactly 4 writes and 1 done; new SB pulsed in the st_done cycle -> accepted and written the next cycle.
- rdy stall: rdy=0 for 2 cycles after the second byte of a SW -> no writes and cnt held; remaining 2 bytes follow at the correct addresses once rdy=1.
- Reset mid-store: assert rst asynchronously after byte 1 of a SW -> all outputs 0 immediately; no further writes and no st_done; a fresh SB after reset completes normally.

Source files
------------

// File: rtl/mem_store_unit.sv
// Commit-stage store responder: serialises one committed store (byte, half or word)
// onto the 8-bit RAM write port, LSB first, then pulses st_done.
module mem_store_unit #(
    parameter int         ADDR_W = 32,
    parameter int         WORD_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              st_ena,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [WORD_W-1:0] st_data,
    input  logic [3:0]        st_len,
    output logic              st_done,
    output logic              st_busy,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_r;
    logic [WORD_W-1:0] data_r;
    logic [1:0]        last_r;
    logic [1:0]        cnt;
    logic              done_r;

    logic io;
    logic fire;
    logic accept;
    logic last_byte;
    logic unused_len;

    // Only the low two bits of the length code select the byte count.
    assign unused_len = ^st_len[3:2];

    assign io        = (addr_r[17:16] == IO_HI);
    assign fire      = (state == WRITE) && mem_gnt && rdy && !(io && io_buffer_full);
    assign accept    = (state == IDLE) && rdy && st_ena;
    assign last_byte = (cnt == last_r);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)              state_next = WRITE;
            WRITE:   if (fire && last_byte)   state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            data_r <= '0;
            last_r <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            // done_r is a one-cycle pulse, so it clears even while rdy is low.
            done_r <= fire && last_byte;
            if (accept) begin
                addr_r <= st_addr;
                data_r <= st_data;
                last_r <= st_len[1:0];
                cnt    <= 2'd0;
            end else if (fire && !last_byte) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        if (fire) begin
            mem_wr   = 1'b1;
            mem_a    = addr_r + ADDR_W'(cnt);
            mem_dout = data_r[{cnt, 3'b000} +: 8];
        end
    end

    assign mem_req = (state == WRITE);
    assign st_busy = (state == WRITE);
    assign st_done = done_r;

endmodule
